sim_uart_arbiter: RTL
=====================

// Module: sim_uart_arbiter
// PURPOSE
//   Shares the single simulation console channel (UART out -> $fwrite in the top)
//   between N_SRC requesters (e.g. per-core UARTs in a multi-core SimTop).
//   Arbitration is round-robin at line granularity: once granted, a source owns
//   the console until it sends '\n', hits MAX_LINE chars, or idles IDLE_TIMEOUT cycles.
//   Prevents interleaved characters from different harts in the console log.
// PARAMETERS
//   N_SRC         4     number of requesters (>=2)
//   MAX_LINE      128   max chars per grant before forced release (>=2)
//   IDLE_TIMEOUT  1024  consecutive cycles without req_valid from owner -> release (>=1)
// PORTS
//   clock          in   1          clock
//   reset          in   1          synchronous, active-low reset
//   req_valid      in   N_SRC      per-source char valid
//   req_ch         in   8*N_SRC    per-source char; source i at [8*i+7:8*i]
//   req_ready      out  N_SRC      per-source accept; at most one bit set
//   out_valid      out  1          console char valid
//   out_ch         out  8          console char
//   out_ready      in   1          console accept (top ties 1)
//   grant_valid    out  1          a source currently owns the console
//   grant_id       out  clog2(N)   owning source index (valid when grant_valid)
//   timeout_pulse  out  1          1-cycle pulse when a grant is released by idle timeout
// BEHAVIOUR
//   Reset (reset==0 at posedge): state=IDLE, grant_valid=0, grant_id=0, char_cnt=0,
//   idle_cnt=0, last=N_SRC-1 (source 0 has top priority first), timeout_pulse=0.
//   Combinationally out_valid=0, req_ready=0 while in IDLE or in reset.
//   FSM IDLE:
//     - any req_valid: pick first set bit scanning last+1, last+2, ... mod N_SRC;
//       register grant_id, grant_valid=1, state->LOCKED. 1-cycle arbitration
//       latency; no char transfers in IDLE cycle.
//   FSM LOCKED (owner g=grant_id):
//     - out_valid=req_valid[g], out_ch=req_ch[g], req_ready[g]=out_ready, others 0
//       (combinational passthrough, zero added latency).
//     - transfer = req_valid[g] & out_ready; on transfer char_cnt++ , idle_cnt=0.
//     - release on transfer if out_ch==8'h0a or char_cnt==MAX_LINE-1 (the
//       MAX_LINE-th char is the last of the grant).
//     - if !req_valid[g]: idle_cnt++; when idle_cnt reaches IDLE_TIMEOUT-1 ->
//       release, timeout_pulse=1 next cycle.
//     - req_valid[g] & !out_ready: stall, neither counter changes state except
//       idle_cnt is cleared (owner is active).
//     - release: state->IDLE, grant_valid=0, last=g, char_cnt=0, idle_cnt=0.
//       Next owner granted earliest in the following IDLE cycle (owner of a
//       just-released line cannot be regranted while another source is valid).
//   Widths: char_cnt clog2(MAX_LINE) bits, idle_cnt clog2(IDLE_TIMEOUT)+1 bits,
//   never wrap (reset on release). grant_id wraps mod N_SRC in RR scan.
//   Simultaneous: newline transfer in same cycle as idle limit impossible
//   (transfer clears idle); newline and MAX_LINE limit together -> single release.
//   Reset mid-line: grant dropped immediately, partial line is not completed.
//   Sources must hold req_valid/req_ch stable until req_ready (valid/ready rule).
// TESTING
//   1 reset held 5 cycles, all req_valid=1 -> out_valid=0, req_ready=0, grant_valid=0.
//   2 src0 sends "hi\n", src1 valid with 'A' throughout -> out_ch 'h','i',8'h0a
//     from src0 then IDLE 1 cycle then src1 granted (grant_id=1).
//   3 all 4 sources send "x\n" continuously -> grant order 0,1,2,3,0; no interleave.
//   4 src2 sends 200 chars no newline, MAX_LINE=128 -> release after 128th char,
//     src2 regranted only if no other source valid.
//   5 src1 sends 'a' then drops valid, IDLE_TIMEOUT=16 -> release 16 cycles later,
//     timeout_pulse=1 for exactly 1 cycle, grant_valid=0.
//   6 out_ready=0 for 50 cycles mid-line -> no timeout, char held stable, resumes.

Source files
------------

// File: rtl/sim_uart_arbiter.sv
// Line-granular round-robin arbiter sharing one simulation console between N_SRC UART sources.
// A source keeps the console until newline, MAX_LINE chars, or IDLE_TIMEOUT quiet cycles.
module sim_uart_arbiter #(
  parameter int N_SRC        = 4,
  parameter int MAX_LINE     = 128,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_SRC-1:0]         req_valid,
  input  logic [8*N_SRC-1:0]       req_ch,
  output logic [N_SRC-1:0]         req_ready,
  output logic                     out_valid,
  output logic [7:0]               out_ch,
  input  logic                     out_ready,
  output logic                     grant_valid,
  output logic [$clog2(N_SRC)-1:0] grant_id,
  output logic                     timeout_pulse
);
  localparam int GW = $clog2(N_SRC);
  localparam int CW = $clog2(MAX_LINE);
  localparam int IW = $clog2(IDLE_TIMEOUT) + 1;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic [GW-1:0] last_q, last_d;
  logic [CW-1:0] char_cnt_q, char_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          timeout_pulse_q, timeout_pulse_d;

  logic          owner_valid;
  logic [7:0]    owner_ch;
  logic          transfer;
  logic          release_line;
  logic          found;
  logic [GW-1:0] pick;
  logic [GW-1:0] idx;

  always_comb begin
    state_d         = state_q;
    grant_id_d      = grant_id_q;
    last_d          = last_q;
    char_cnt_d      = char_cnt_q;
    idle_cnt_d      = idle_cnt_q;
    timeout_pulse_d = 1'b0;
    release_line    = 1'b0;
    found           = 1'b0;
    pick            = '0;
    idx             = '0;
    req_ready       = '0;
    out_valid       = 1'b0;

    owner_valid = req_valid[grant_id_q];
    owner_ch    = req_ch[{grant_id_q, 3'b000} +: 8];
    out_ch      = owner_ch;
    transfer    = (state_q == S_LOCKED) && owner_valid && out_ready;

    // Scan starts just after the previous owner so a released source goes last.
    for (int k = 1; k <= N_SRC; k++) begin
      idx = GW'((int'(last_q) + k) % N_SRC);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_LOCKED;
          grant_id_d = pick;
        end
      end
      S_LOCKED: begin
        out_valid             = reset && owner_valid;
        req_ready[grant_id_q] = reset && out_ready;
        if (transfer) begin
          idle_cnt_d = '0;
          if (owner_ch == 8'h0a || char_cnt_q == CW'(MAX_LINE - 1))
            release_line = 1'b1;
          else
            char_cnt_d = char_cnt_q + 1'b1;
        end else if (owner_valid) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IW'(IDLE_TIMEOUT - 1)) begin
          release_line    = 1'b1;
          timeout_pulse_d = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
        if (release_line) begin
          state_d    = S_IDLE;
          last_d     = grant_id_q;
          char_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      grant_id_q      <= '0;
      last_q          <= GW'(N_SRC - 1);
      char_cnt_q      <= '0;
      idle_cnt_q      <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_id_q      <= grant_id_d;
      last_q          <= last_d;
      char_cnt_q      <= char_cnt_d;
      idle_cnt_q      <= idle_cnt_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  // A reset mid-line drops the grant in the same cycle.
  assign grant_valid   = reset && (state_q == S_LOCKED);
  assign grant_id      = grant_id_q;
  assign timeout_pulse = timeout_pulse_q;
endmodule
